// File: rtl/sw_target_scheduler.sv
// sw_target_scheduler: round-robin dispatcher of packed target records
// (ID | length | 2-bit bases) onto NUM_LANES feeder/scoring lanes.
// Dispatch is gated by feeder `full` and a per-lane in-flight limit;
// records with a length of zero or above TARGET_LENGTH are dropped.
// Optional feature macro: SCHED_STATS_EN enables the dispatched/dropped
// counters; without it both counter ports are tied to zero.
module sw_target_scheduler #(
  parameter int NUM_LANES     = 4,
  parameter int TARGET_LENGTH = 128,
  parameter int LEN_WIDTH     = 12,
  parameter int ID_WIDTH      = 48,
  parameter int MAX_INFLIGHT  = 3,
  parameter int IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic [NUM_LANES-1:0] lane_full,
  input  logic [NUM_LANES-1:0] lane_done,
  output logic [NUM_LANES-1:0] ld,
  output logic [IN_WIDTH-1:0]  feed_out,
  output logic                 idle,
  output logic                 err_len,
  output logic                 err_done,
  output logic [31:0]          dispatched_cnt,
  output logic [15:0]          dropped_cnt
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_LOAD, S_GUARD} state_t;

  state_t               r_state;
  logic [IN_WIDTH-1:0]  r_hold;
  logic [IN_WIDTH-1:0]  r_feed;
  logic                 r_bad;
  logic [NUM_LANES-1:0] r_ld;
  logic [LANE_W-1:0]    r_sel;
  logic [LANE_W-1:0]    r_last;
  logic                 r_guard;
  logic                 r_err_len;
  logic                 r_err_done;
  logic [2:0]           r_infl [NUM_LANES];

  logic [LEN_WIDTH-1:0] w_len;
  logic                 w_len_bad;
  logic                 w_found;
  logic [LANE_W-1:0]    w_pick;
  logic [NUM_LANES-1:0] w_onehot;
  logic [2:0]           w_infl_nxt [NUM_LANES];
  logic                 w_err_done;
  logic                 w_all_zero;

  // Length is validated when the record is accepted so the error pulse
  // lands in the cycle right after the handshake.
  assign w_len     = s_data[2*TARGET_LENGTH +: LEN_WIDTH];
  assign w_len_bad = (w_len == {LEN_WIDTH{1'b0}}) || (w_len > LEN_WIDTH'(TARGET_LENGTH));
  assign w_onehot  = {{(NUM_LANES-1){1'b0}}, 1'b1} << w_pick;

  // Round-robin search starting just after the last loaded lane.
  always_comb begin
    logic [LANE_W-1:0] idx;
    w_found = 1'b0;
    w_pick  = r_last;
    idx     = r_last;
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx = LANE_W'((int'(r_last) + i) % NUM_LANES);
      if (!w_found && !lane_full[idx] && (r_infl[idx] < 3'(MAX_INFLIGHT))) begin
        w_found = 1'b1;
        w_pick  = idx;
      end else begin
        w_pick  = w_pick;
      end
    end
  end

  // Next in-flight counts: load increment, done decrement, done-at-zero error.
  always_comb begin
    logic inc;
    w_err_done = 1'b0;
    w_all_zero = 1'b1;
    inc        = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      inc           = (r_state == S_LOAD) && r_ld[k];
      w_infl_nxt[k] = r_infl[k];
      case ({inc, lane_done[k]})
        2'b10: w_infl_nxt[k] = r_infl[k] + 3'd1;
        2'b01: begin
          if (r_infl[k] != 3'd0) begin
            w_infl_nxt[k] = r_infl[k] - 3'd1;
          end else begin
            w_err_done = 1'b1;
          end
        end
        default: w_infl_nxt[k] = r_infl[k];
      endcase
      if (r_infl[k] != 3'd0) begin
        w_all_zero = 1'b0;
      end else begin
        w_all_zero = w_all_zero;
      end
    end
  end

  // Scheduler FSM: accept, arbitrate, one-cycle load strobe, two-cycle guard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_feed    <= '0;
      r_bad     <= 1'b0;
      r_ld      <= '0;
      r_sel     <= '0;
      r_last    <= LANE_W'(NUM_LANES - 1);
      r_guard   <= 1'b0;
      r_err_len <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ld <= '0;
          if (s_valid) begin
            r_hold    <= s_data;
            r_bad     <= w_len_bad;
            r_err_len <= w_len_bad;
            r_state   <= S_ARB;
          end else begin
            r_err_len <= 1'b0;
          end
        end
        S_ARB: begin
          r_err_len <= 1'b0;
          if (r_bad) begin
            r_state <= S_IDLE;
          end else if (w_found) begin
            r_ld    <= w_onehot;
            r_sel   <= w_pick;
            r_feed  <= r_hold;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_ARB;
          end
        end
        S_LOAD: begin
          r_ld    <= '0;
          r_last  <= r_sel;
          r_guard <= 1'b0;
          r_state <= S_GUARD;
        end
        S_GUARD: begin
          // Feeder `full` lags a load by its input register, so wait two cycles.
          if (r_guard) begin
            r_state <= S_IDLE;
          end else begin
            r_guard <= 1'b1;
          end
        end
        default: begin
          r_ld    <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Per-lane in-flight counters and the done-at-zero error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        r_infl[k] <= 3'd0;
      end
      r_err_done <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        r_infl[k] <= w_infl_nxt[k];
      end
      r_err_done <= w_err_done;
    end
  end

`ifdef SCHED_STATS_EN
  logic [31:0] r_disp_cnt;
  logic [15:0] r_drop_cnt;

  // Statistics: dispatched wraps, dropped saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_cnt <= 32'd0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (r_state == S_LOAD) begin
        r_disp_cnt <= r_disp_cnt + 32'd1;
      end else begin
        r_disp_cnt <= r_disp_cnt;
      end
      if ((r_state == S_IDLE) && s_valid && w_len_bad && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
    end
  end

  assign dispatched_cnt = r_disp_cnt;
  assign dropped_cnt    = r_drop_cnt;
`else
  assign dispatched_cnt = 32'd0;
  assign dropped_cnt    = 16'd0;
`endif

  assign s_ready  = (r_state == S_IDLE) && !rst;
  assign idle     = (r_state == S_IDLE) && w_all_zero;
  assign ld       = r_ld;
  assign feed_out = r_feed;
  assign err_len  = r_err_len;
  assign err_done = r_err_done;

endmodule
